// File: rtl/ex_alu_muldiv.sv
// EX-stage execute unit: single-cycle ALU plus iterative MUL/DIV/REM with flush and divide-by-zero flag.
// Optional MEM>WB operand forwarding is enabled by defining ALU_FWD_EN.
module ex_alu_muldiv #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op_type,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic [DATA_W-1:0]     imm_ext,
    input  logic                  mem_we,
    input  logic [REG_ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0]     wb_wdata,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     result,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_LW  = 4'b0110;
    localparam logic [3:0] OP_SW  = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011;
    localparam logic [3:0] OP_REM = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] opa_p0, opb_p0;
    logic              accept_p0, is_div_p0, div_zero_p0;

    logic [DATA_W-1:0] a_p1, b_p1, acc_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic              rem_sel_p1, last_iter_p1;
    logic [DATA_W-1:0] prod_nxt_p1, quo_nxt_p1, rem_nxt_p1;
    logic [DATA_W:0]   div_shift_p1, div_diff_p1;
    logic              div_ge_p1;

    logic [DATA_W-1:0] result_p1;
    logic              vld_p1, dbz_p1;

    function automatic logic [DATA_W-1:0] alu_single(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD, OP_LW, OP_SW: r = a + b;
            OP_SUB:               r = a - b;
            OP_AND:               r = a & b;
            OP_OR:                r = a | b;
            OP_SLT:               r = DATA_W'(a < b);
            OP_BEQ:               r = DATA_W'(a == b);
            default:              r = '0;
        endcase
        return r;
    endfunction

    // ---- p0: operand selection and issue ----
    always_comb begin
        opa_p0 = rs_data;
        opb_p0 = rt_data;
`ifdef ALU_FWD_EN
        // r0 is hard-wired zero, so a pending write to it must never be forwarded.
        if (mem_we && mem_waddr == rs_addr && rs_addr != '0)
            opa_p0 = mem_wdata;
        else if (wb_we && wb_waddr == rs_addr && rs_addr != '0)
            opa_p0 = wb_wdata;
        if (mem_we && mem_waddr == rt_addr && rt_addr != '0)
            opb_p0 = mem_wdata;
        else if (wb_we && wb_waddr == rt_addr && rt_addr != '0)
            opb_p0 = wb_wdata;
`endif
        if (op_type == OP_LW || op_type == OP_SW)
            opb_p0 = imm_ext;
    end

`ifndef ALU_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata, rs_addr, rt_addr};
`endif

    assign in_ready    = (state == ST_IDLE);
    assign accept_p0   = in_valid && (state == ST_IDLE) && !flush;
    assign is_div_p0   = (op_type == OP_DIV) || (op_type == OP_REM);
    assign div_zero_p0 = (opb_p0 == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_p0) begin
                    if (op_type == OP_MUL)
                        state_nxt = ST_MUL;
                    else if (is_div_p0 && !div_zero_p0)
                        state_nxt = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (last_iter_p1)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush)
            state_nxt = ST_IDLE;
    end

    // ---- p1: iteration datapath and registered result ----
    assign last_iter_p1 = (cnt_p1 == CNT_W'(DATA_W - 1));
    assign prod_nxt_p1  = acc_p1 + (b_p1[0] ? a_p1 : '0);
    // Partial remainder needs one extra bit so the shift cannot overflow for divisors >= 2^(DATA_W-1).
    assign div_shift_p1 = {acc_p1, a_p1[DATA_W-1]};
    assign div_diff_p1  = div_shift_p1 - {1'b0, b_p1};
    assign div_ge_p1    = (div_shift_p1 >= {1'b0, b_p1});
    assign rem_nxt_p1   = div_ge_p1 ? div_diff_p1[DATA_W-1:0] : div_shift_p1[DATA_W-1:0];
    assign quo_nxt_p1   = {a_p1[DATA_W-2:0], div_ge_p1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_p1       <= '0;
            b_p1       <= '0;
            acc_p1     <= '0;
            cnt_p1     <= '0;
            rem_sel_p1 <= 1'b0;
            result_p1  <= '0;
            vld_p1     <= 1'b0;
            dbz_p1     <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            dbz_p1 <= 1'b0;
            if (flush) begin
                cnt_p1 <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept_p0) begin
                            cnt_p1 <= '0;
                            if (op_type == OP_MUL) begin
                                a_p1   <= opa_p0;
                                b_p1   <= opb_p0;
                                acc_p1 <= '0;
                            end else if (is_div_p0) begin
                                if (div_zero_p0) begin
                                    vld_p1    <= 1'b1;
                                    dbz_p1    <= 1'b1;
                                    result_p1 <= (op_type == OP_DIV) ? '1 : opa_p0;
                                end else begin
                                    a_p1       <= opa_p0;
                                    b_p1       <= opb_p0;
                                    acc_p1     <= '0;
                                    rem_sel_p1 <= (op_type == OP_REM);
                                end
                            end else begin
                                vld_p1    <= 1'b1;
                                result_p1 <= alu_single(op_type, opa_p0, opb_p0);
                            end
                        end
                    end
                    ST_MUL: begin
                        acc_p1 <= prod_nxt_p1;
                        a_p1   <= a_p1 << 1;
                        b_p1   <= b_p1 >> 1;
                        cnt_p1 <= cnt_p1 + CNT_W'(1);
                        if (last_iter_p1) begin
                            result_p1 <= prod_nxt_p1;
                            vld_p1    <= 1'b1;
                            cnt_p1    <= '0;
                        end
                    end
                    ST_DIV: begin
                        acc_p1 <= rem_nxt_p1;
                        a_p1   <= quo_nxt_p1;
                        cnt_p1 <= cnt_p1 + CNT_W'(1);
                        if (last_iter_p1) begin
                            result_p1 <= rem_sel_p1 ? rem_nxt_p1 : quo_nxt_p1;
                            vld_p1    <= 1'b1;
                            cnt_p1    <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid   = vld_p1;
    assign result      = result_p1;
    assign div_by_zero = dbz_p1;

endmodule
